// File: rtl/shift_add_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
package shift_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Result width: the multiplicand, the largest possible shift, and headroom
    // for summing max_terms terms plus a sign bit.
    function automatic int calc_c_w(input int a_w, input int sh_w, input int max_terms);
        return a_w + (1 << sh_w) + $clog2(max_terms) + 1;
    endfunction

endpackage

// File: rtl/shift_add_term.sv
// One signed power-of-two term: +/- (a << shift) at the full result width.
module shift_add_term
    import shift_add_pkg::*;
#(
    parameter int A_W = 8,
    parameter int SH_W = 3,
    parameter int C_W = 19
) (
    input  logic signed [A_W-1:0] a,
    input  logic        [SH_W-1:0] shift,
    input  logic                  sign,
    output logic signed [C_W-1:0] term
);

    logic signed [C_W-1:0] a_ext;
    logic signed [C_W-1:0] shifted;

    // Sign-extend before shifting so the most negative a stays exact, then negate at full width.
    always_comb begin
        a_ext   = {{(C_W-A_W){a[A_W-1]}}, a};
        shifted = a_ext <<< shift;
        term    = sign ? -shifted : shifted;
    end

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential multiplier that accumulates up to MAX_TERMS signed power-of-two
// terms of a, one term per clock, using a single shared term generator.
module shift_add_mult_seq
    import shift_add_pkg::*;
#(
    parameter int A_W = 8,
    parameter int SH_W = 3,
    parameter int MAX_TERMS = 4,
    localparam int C_W = calc_c_w(A_W, SH_W, MAX_TERMS),
    localparam int NT_W = $clog2(MAX_TERMS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic signed [A_W-1:0]       a,
    input  logic [MAX_TERMS*SH_W-1:0]   shifts,
    input  logic [MAX_TERMS-1:0]        signs,
    input  logic [NT_W-1:0]             num_terms,
    output logic signed [C_W-1:0]       c,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic                        busy
);

    state_t state;
    state_t next_state;

    logic signed [A_W-1:0]         a_r;
    logic [MAX_TERMS*SH_W-1:0]     shifts_r;
    logic [MAX_TERMS-1:0]          signs_r;
    logic [NT_W-1:0]               n_r;
    logic [NT_W-1:0]               idx;
    logic signed [C_W-1:0]         acc;

    logic [NT_W-1:0]               n_eff;
    logic                          accept;
    logic                          last_term;
    logic [SH_W-1:0]               cur_shift;
    logic                          cur_sign;
    logic signed [C_W-1:0]         term;
    logic signed [C_W-1:0]         sum_next;

    // Clamp the requested term count and flag the final accumulation step.
    always_comb begin
        n_eff     = (num_terms > NT_W'(MAX_TERMS)) ? NT_W'(MAX_TERMS) : num_terms;
        last_term = (idx == n_r - NT_W'(1));
        sum_next  = acc + term;
    end

    // Select the shift and sign of the term addressed by the current index.
    always_comb begin
        cur_shift = '0;
        cur_sign  = 1'b0;
        for (int k = 0; k < MAX_TERMS; k++) begin
            if (idx == NT_W'(k)) begin
                cur_shift = shifts_r[k*SH_W +: SH_W];
                cur_sign  = signs_r[k];
            end
        end
    end

    shift_add_term #(
        .A_W  (A_W),
        .SH_W (SH_W),
        .C_W  (C_W)
    ) u_term (
        .a     (a_r),
        .shift (cur_shift),
        .sign  (cur_sign),
        .term  (term)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        next_state = state;
        in_rdy     = 1'b0;
        out_vld    = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                busy   = 1'b0;
                if (in_vld) begin
                    accept     = 1'b1;
                    next_state = (n_eff == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_term) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the request, step through terms, and publish the sum only when it is final.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            shifts_r <= '0;
            signs_r  <= '0;
            n_r      <= '0;
            idx      <= '0;
            acc      <= '0;
            c        <= '0;
        end else if (accept) begin
            a_r      <= a;
            shifts_r <= shifts;
            signs_r  <= signs;
            n_r      <= n_eff;
            idx      <= '0;
            acc      <= '0;
            if (n_eff == '0) begin
                c <= '0;
            end
        end else if (state == ACCUM) begin
            acc <= sum_next;
            idx <= idx + NT_W'(1);
            if (last_term) begin
                c <= sum_next;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed and randomized self-checking bench for shift_add_mult_seq.
module tb_shift_add_mult_seq;

    logic               clk;
    logic               rst_n;
    logic               in_vld;
    logic               in_rdy;
    logic signed [7:0]  a;
    logic [11:0]        shifts;
    logic [3:0]         signs;
    logic [2:0]         num_terms;
    logic signed [18:0] c;
    logic               out_vld;
    logic               out_rdy;
    logic               busy;

    int checks = 0;
    int errors = 0;

    shift_add_mult_seq #(
        .A_W       (8),
        .SH_W      (3),
        .MAX_TERMS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .a         (a),
        .shifts    (shifts),
        .signs     (signs),
        .num_terms (num_terms),
        .c         (c),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic, term count clamped to 4.
    function automatic int ref_model(input int av, input logic [11:0] sh, input logic [3:0] sg, input int nt);
        int n;
        int s;
        int t;
        s = 0;
        n = (nt > 4) ? 4 : nt;
        for (int k = 0; k < n; k++) begin
            t = av * (1 << sh[k*3 +: 3]);
            s = sg[k] ? s - t : s + t;
        end
        return s;
    endfunction

    task automatic drive_req(input logic signed [7:0] ta, input logic [11:0] tsh,
                             input logic [3:0] tsg, input logic [2:0] tn);
        a         = ta;
        shifts    = tsh;
        signs     = tsg;
        num_terms = tn;
        in_vld    = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL reset_flags: in_rdy=%b out_vld=%b busy=%b expected 1 0 0", in_rdy, out_vld, busy);
        checks++;
        if (c !== 19'sd0) begin
            errors++;
            $display("[TB] FAIL reset_c: got %0d expected 0", c);
        end
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || busy !== 1'b0) errors++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive_req(8'sd5, 12'h003, 4'b0010, 3'd2);
        @(negedge clk);
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_e0: out_vld=%b busy=%b expected 0 1", out_vld, busy);
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_e1: out_vld=%b expected 0", out_vld);
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || c !== 19'sd35) begin
            errors++;
            $display("[TB] FAIL basic_e2: out_vld=%b c=%0d expected 1 35", out_vld, c);
        end
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || c !== 19'sd35) begin
            errors++;
            $display("[TB] FAIL basic_hold: in_rdy=%b out_vld=%b c=%0d expected 1 0 35", in_rdy, out_vld, c);
        end
    endtask

    task automatic test_most_negative();
        drive_req(-8'sd128, 12'h007, 4'b0001, 3'd1);
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || c !== 19'sd16384) begin
            errors++;
            $display("[TB] FAIL most_neg: out_vld=%b c=%0d expected 1 16384", out_vld, c);
        end
        @(negedge clk);
    endtask

    task automatic test_clamp();
        logic [2:0] counts [2];
        counts[0] = 3'd4;
        counts[1] = 3'd7;
        for (int r = 0; r < 2; r++) begin
            drive_req(-8'sd3, 12'h688, 4'b0000, counts[r]);
            @(negedge clk);
            in_vld = 1'b0;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clamp_early n=%0d: out_vld=%b expected 0", counts[r], out_vld);
            end
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || c !== -19'sd45) begin
                errors++;
                $display("[TB] FAIL clamp_sum n=%0d: out_vld=%b c=%0d expected 1 -45", counts[r], out_vld, c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_terms();
        drive_req(8'sd9, 12'h249, 4'b1111, 3'd0);
        @(negedge clk);
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b1 || c !== 19'sd0) begin
            errors++;
            $display("[TB] FAIL zero_terms: out_vld=%b c=%0d expected 1 0", out_vld, c);
        end
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_terms_idle: in_rdy=%b expected 1", in_rdy);
        end
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        drive_req(8'sd2, 12'h001, 4'b0000, 3'd1);
        @(negedge clk);
        drive_req(8'sd7, 12'h007, 4'b0000, 3'd1);
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || c !== 19'sd4) begin
            errors++;
            $display("[TB] FAIL bp_done: out_vld=%b c=%0d expected 1 4", out_vld, c);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || c !== 19'sd4 || in_rdy !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d: out_vld=%b c=%0d in_rdy=%b busy=%b expected 1 4 0 1",
                         i, out_vld, c, in_rdy, busy);
            end
        end
        drive_req(8'sd1, 12'h000, 4'b0000, 3'd1);
        out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release: in_rdy=%b out_vld=%b expected 1 0", in_rdy, out_vld);
        end
        @(negedge clk);
        in_vld = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_accept: busy=%b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || c !== 19'sd1) begin
            errors++;
            $display("[TB] FAIL bp_second: out_vld=%b c=%0d expected 1 1", out_vld, c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_req(-8'sd3, 12'h688, 4'b0000, 3'd4);
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vld !== 1'b0 || c !== 19'sd0 || busy !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset: out_vld=%b c=%0d busy=%b in_rdy=%b expected 0 0 0 1",
                     out_vld, c, busy, in_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(8'sd1, 12'h002, 4'b0000, 3'd1);
        @(negedge clk);
        in_vld = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_accept: busy=%b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1 || c !== 19'sd4) begin
            errors++;
            $display("[TB] FAIL post_reset_sum: out_vld=%b c=%0d expected 1 4", out_vld, c);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic signed [7:0]  ra;
        logic [11:0]        rsh;
        logic [3:0]         rsg;
        logic [2:0]         rn;
        logic signed [18:0] exp_c;
        int                 exp_sum;
        int                 exp_lat;
        int                 lat;
        out_rdy = 1'b1;
        for (int t = 0; t < 10000; t++) begin
            ra      = 8'($urandom_range(0, 255));
            rsh     = 12'($urandom);
            rsg     = 4'($urandom);
            rn      = 3'($urandom_range(0, 7));
            exp_sum = ref_model(int'(ra), rsh, rsg, int'(rn));
            exp_c   = exp_sum[18:0];
            exp_lat = (rn > 3'd4) ? 4 : int'(rn);
            drive_req(ra, rsh, rsg, rn);
            @(negedge clk);
            lat = 0;
            while (out_vld !== 1'b1 && lat < 6) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("[TB] FAIL b2b_latency #%0d: got %0d edges expected %0d", t, lat, exp_lat);
            end
            checks++;
            if (c !== exp_c) begin
                errors++;
                $display("[TB] FAIL b2b_value #%0d: got %0d expected %0d", t, c, exp_c);
            end
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready #%0d: in_rdy=%b expected 1", t, in_rdy);
            end
        end
        in_vld = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst_n     = 1'b0;
        in_vld    = 1'b0;
        out_rdy   = 1'b1;
        a         = '0;
        shifts    = '0;
        signs     = '0;
        num_terms = '0;
        test_reset();
        test_basic();
        test_most_negative();
        test_clamp();
        test_zero_terms();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_seq.md
SHIFT_ADD_MULT_SEQ -- requirements
Module: shift_add_mult_seq

Interface
REQ-001 Parameter A_W, default 8: width of signed multiplicand a.
REQ-002 Parameter SH_W, default 3: width of each term shift amount.
REQ-003 Parameter MAX_TERMS, default 4, minimum 1: maximum signed power-of-two terms per weight.
REQ-004 Derived constants: C_W = A_W + (1<<SH_W) + $clog2(MAX_TERMS) + 1 (result width); NT_W = $clog2(MAX_TERMS+1) (term-count width).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_vld  input  1  request valid.
REQ-008 in_rdy  output  1  block can accept a request.
REQ-009 a  input  A_W  signed multiplicand.
REQ-010 shifts  input  MAX_TERMS*SH_W  packed shift amounts; term k in bits [k*SH_W +: SH_W].
REQ-011 signs  input  MAX_TERMS  term k is subtracted when signs[k]=1, added when 0.
REQ-012 num_terms  input  NT_W  number of terms to apply, starting at term 0.
REQ-013 c  output  C_W  signed result, sum over k<num_terms of (signs[k] ? -1 : +1) * (a << shifts[k]).
REQ-014 out_vld  output  1  c is valid.
REQ-015 out_rdy  input  1  consumer accepts c.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ACCUM, DONE.
REQ-018 in_rdy SHALL equal (state==IDLE); a request is accepted on a rising edge where in_vld && in_rdy.
REQ-019 On accept, the block SHALL register a, shifts, signs and the effective count n = min(num_terms, MAX_TERMS), clear the accumulator and clear the term index.
- Next state: ACCUM if n>0, DONE if n==0.
REQ-020 In ACCUM, each edge SHALL add term[index] to the accumulator and increment the index; after the edge that applies term n-1, state goes to DONE.
REQ-021 Term arithmetic: a is sign-extended to C_W before shifting; negation is two's complement at C_W. a = -2^(A_W-1) SHALL produce an exact result with no overflow.
REQ-022 Latency: for a request accepted at edge E, out_vld SHALL rise after edge E+n (n=0 gives E).
REQ-023 In DONE, out_vld=1 and c holds the final sum; c and out_vld SHALL stay stable until an edge with out_rdy=1, which moves the FSM to IDLE.
REQ-024 in_vld SHALL be ignored in ACCUM and DONE; inputs other than in_vld/out_rdy are don't-care outside the accept edge.
REQ-025 Outside DONE, out_vld=0 and c SHALL hold its last value (0 after reset).
REQ-026 Throughput: one request per n+2 cycles with out_rdy held high; no input/output overlap.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, accumulator/c=0, index=0, out_vld=0, busy=0 and in_rdy=1, including mid-ACCUM or in DONE; the in-flight request is discarded.
REQ-028 The first accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package shift_add_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and a width function computing C_W from A_W, SH_W and MAX_TERMS.
REQ-030 Combinational sub-module shift_add_term SHALL produce one signed term of width C_W from (a, shift, sign); a single instance is shared across cycles.

Verification (A_W=8, SH_W=3, MAX_TERMS=4, C_W=19)
REQ-031 a=5, shifts{3,0}, signs{0,1}, n=2 -> c=35; out_vld rises exactly 2 edges after accept.
REQ-032 a=-128, shift{7}, sign{1}, n=1 -> c=+16384, no overflow.
REQ-033 a=-3, shifts{0,1,2,3}, signs all 0, n=4 -> c=-45; num_terms=7 with the same data is clamped to 4 -> c=-45; num_terms=0 -> c=0 and out_vld high 1 edge... after accept edge itself.
REQ-034 out_rdy low for 5 cycles in DONE with in_vld held high -> c and out_vld stable, in_rdy=0, no second accept; out_rdy=1 -> IDLE next edge, then the new request is accepted.
REQ-035 rst_n pulsed low mid-ACCUM (n=4, after 2 terms) -> immediately out_vld=0, c=0, busy=0, in_rdy=1; the next request a=1, shift{2}, sign{0}, n=1 -> c=4.
REQ-036 Back-to-back random requests with out_rdy=1, compared against a reference model over 10k transactions -> zero mismatches.
